dma_mc_engine: RTL

Multi-channel, parametrised successor to the single-channel DMA datapath. It sits between the DMA slave configuration FSM and the DMA AXI master FSM. Per channel it holds source, destination and word-count registers, and splits each transfer into store-and-forward bursts of at most BUF_DEPTH beats. Channels are arbitrated round-robin, and each raises its own sticky interrupt on completion.

---
 rtl/dma_mc_engine.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/dma_mc_engine.sv
// Multi-channel store-and-forward DMA engine: per-channel src/dst/len, round-robin burst arbitration.
// Optional DMA_MC_BRESP_CHK_EN adds b_resp input and per-channel err output.
//
// state  | meaning
// IDLE   | no channel armed
// ARB    | pick next armed channel, latch burst size
// RADDR  | read address request outstanding
// RDATA  | collecting read beats into the burst buffer
// WADDR  | write address request outstanding
// WDATA  | draining the burst buffer
// WRESP  | waiting for write response
// UPDATE | advance pointers, retire channel when done
module dma_mc_engine #(
  parameter int CH_NUM    = 2,
  parameter int BUF_DEPTH = 16,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int BW = $clog2(BUF_DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cfg_src_valid,
  input  logic              cfg_dst_valid,
  input  logic              cfg_len_valid,
  input  logic              cfg_start,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [BW-1:0]     ar_len,
  input  logic              r_valid,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_last,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [BW-1:0]     aw_len,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  input  logic              b_valid,
`ifdef DMA_MC_BRESP_CHK_EN
  input  logic [1:0]        b_resp,
  output logic [CH_NUM-1:0] err,
`endif
  output logic [CH_NUM-1:0] busy,
  output logic [CH_NUM-1:0] irq,
  input  logic [CH_NUM-1:0] irq_clr
);

  localparam int BSH = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((DATA_W / 8) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP, S_UPDATE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q [CH_NUM];
  logic [ADDR_W-1:0] dst_q [CH_NUM];
  logic [LEN_W-1:0]  rem_q [CH_NUM];
  logic [CH_NUM-1:0] armed_q, armed_nxt, irq_q, irq_nxt;
  logic [CW-1:0]     cur_q, last_q, pick;
  logic              pick_vld;
  logic [BW:0]       beats_q, pick_beats;
  logic [BW-1:0]     len_q, ridx_q, widx_q;
  logic [LEN_W-1:0]  pick_rem, rem_left;
  logic [ADDR_W-1:0] step;
  logic              bad_q, cfg_ok;
  logic [(1<<CW)-1:0] blocked;
  logic [DATA_W-1:0] buf_mem [BUF_DEPTH];

  assign busy   = armed_q;
  assign irq    = irq_q;
  assign ar_len = len_q;
  assign aw_len = len_q;
  assign w_last = w_valid && (widx_q == len_q);
  assign w_data = w_valid ? buf_mem[widx_q] : '0;

  // A channel in transfer is always armed, so the armed mask alone gates config.
  // Padding with ones rejects channel numbers beyond CH_NUM.
  always_comb begin
    blocked = '1;
    blocked[CH_NUM-1:0] = armed_q;
    cfg_ok = !blocked[cfg_ch];
  end

  // Descending scan so the nearest channel after last_q wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = CH_NUM; i >= 1; i--) begin
      idx = (int'(last_q) + i) % CH_NUM;
      if (armed_q[CW'(idx)]) begin
        pick     = CW'(idx);
        pick_vld = 1'b1;
      end
    end
    pick_rem   = rem_q[pick];
    pick_beats = (pick_rem >= LEN_W'(BUF_DEPTH)) ? (BW+1)'(BUF_DEPTH) : (BW+1)'(pick_rem);
  end

  assign rem_left = rem_q[cur_q] - LEN_W'(beats_q);
  assign step     = ADDR_W'(beats_q) << BSH;

  always_comb begin
    armed_nxt = armed_q;
    irq_nxt   = irq_q & ~irq_clr;
    if (state == S_UPDATE) begin
      if (bad_q) begin
        armed_nxt[cur_q] = 1'b0;
      end else if (rem_left == '0) begin
        armed_nxt[cur_q] = 1'b0;
        irq_nxt[cur_q]   = 1'b1;
      end
    end
    if (cfg_start && cfg_ok) begin
      if (rem_q[cfg_ch] == '0) irq_nxt[cfg_ch] = 1'b1;
      else                     armed_nxt[cfg_ch] = 1'b1;
    end
  end

`ifdef DMA_MC_BRESP_CHK_EN
  logic [CH_NUM-1:0] err_nxt;
  always_comb begin
    err_nxt = err;
    if (state == S_UPDATE && bad_q) err_nxt[cur_q] = 1'b1;
    if (cfg_start && cfg_ok)        err_nxt[cfg_ch] = 1'b0;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) err <= '0;
    else          err <= err_nxt;
  end
`endif

  always_ff @(posedge ACLK) begin
    if (state == S_RDATA && r_valid) buf_mem[ridx_q] <= r_data;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state    <= S_IDLE;
      armed_q  <= '0;
      irq_q    <= '0;
      cur_q    <= '0;
      last_q   <= '0;
      beats_q  <= '0;
      len_q    <= '0;
      ridx_q   <= '0;
      widx_q   <= '0;
      bad_q    <= 1'b0;
      ar_valid <= 1'b0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      ar_addr  <= '0;
      aw_addr  <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        src_q[c] <= '0;
        dst_q[c] <= '0;
        rem_q[c] <= '0;
      end
    end else begin
      armed_q <= armed_nxt;
      irq_q   <= irq_nxt;
      if (cfg_ok) begin
        if (cfg_src_valid) src_q[cfg_ch] <= cfg_data & ADDR_MASK;
        if (cfg_dst_valid) dst_q[cfg_ch] <= cfg_data & ADDR_MASK;
        if (cfg_len_valid) rem_q[cfg_ch] <= cfg_data[LEN_W-1:0];
      end
      case (state)
        S_IDLE: if (|armed_q) state <= S_ARB;
        S_ARB: begin
          if (pick_vld) begin
            cur_q    <= pick;
            last_q   <= pick;
            beats_q  <= pick_beats;
            len_q    <= BW'(pick_beats - (BW+1)'(1));
            ar_addr  <= src_q[pick];
            aw_addr  <= dst_q[pick];
            ar_valid <= 1'b1;
            ridx_q   <= '0;
            state    <= S_RADDR;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RADDR: if (ar_ready) begin
          ar_valid <= 1'b0;
          state    <= S_RDATA;
        end
        S_RDATA: if (r_valid) begin
          ridx_q <= ridx_q + 1'b1;
          if (r_last) begin
            aw_valid <= 1'b1;
            state    <= S_WADDR;
          end
        end
        S_WADDR: if (aw_ready) begin
          aw_valid <= 1'b0;
          w_valid  <= 1'b1;
          widx_q   <= '0;
          state    <= S_WDATA;
        end
        S_WDATA: if (w_ready) begin
          widx_q <= widx_q + 1'b1;
          if (w_last) begin
            w_valid <= 1'b0;
            state   <= S_WRESP;
          end
        end
        S_WRESP: if (b_valid) begin
`ifdef DMA_MC_BRESP_CHK_EN
          bad_q <= (b_resp != 2'b00);
`else
          bad_q <= 1'b0;
`endif
          state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (!bad_q) begin
            src_q[cur_q] <= src_q[cur_q] + step;
            dst_q[cur_q] <= dst_q[cur_q] + step;
            rem_q[cur_q] <= rem_left;
          end
          state <= (|armed_nxt) ? S_ARB : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
